// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed XLEN+3 cycle latency with a single registered register-file write-back.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wr_en,
  output logic [4:0]      wr_rd,
  output logic [XLEN-1:0] wr_data
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_a_orig;
  logic [XLEN-1:0] r_bmag;
  logic            r_b_zero;
  logic            r_ovf;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic [CW-1:0]   r_cnt;
  // r_hi/r_lo hold {product high, product low} or {remainder, quotient}
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  logic            r_busy;
  logic            r_done;
  logic            r_wr_en;
  logic [4:0]      r_wr_rd;
  logic [XLEN-1:0] r_wr_data;

  logic            w_sa;
  logic            w_sb;
  logic            w_signed_div;
  logic [XLEN-1:0] w_amag;
  logic [XLEN-1:0] w_bmag;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_hi_next;
  logic [XLEN-1:0] w_lo_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_result;

  // Operand sign extraction at issue time
  always_comb begin
    w_sa         = 1'b0;
    w_sb         = 1'b0;
    w_signed_div = 1'b0;
    case (funct3)
      OP_MULH: begin
        w_sa = rs1_val[XLEN-1];
        w_sb = rs2_val[XLEN-1];
      end
      OP_MULHSU: begin
        w_sa = rs1_val[XLEN-1];
      end
      OP_DIV, OP_REM: begin
        w_sa         = rs1_val[XLEN-1];
        w_sb         = rs2_val[XLEN-1];
        w_signed_div = 1'b1;
      end
      default: begin
        w_sa = 1'b0;
        w_sb = 1'b0;
      end
    endcase
    w_amag = w_sa ? (~rs1_val + 1'b1) : rs1_val;
    w_bmag = w_sb ? (~rs2_val + 1'b1) : rs2_val;
  end

  // One iteration step: shift-add multiply or restoring divide
  always_comb begin
    w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_bmag} : '0);
    w_shift   = {r_hi, r_lo[XLEN-1]};
    w_diff    = w_shift - {1'b0, r_bmag};
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    if (r_op[2]) begin
      if (!w_diff[XLEN]) begin
        w_hi_next = w_diff[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_next = w_shift[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_next = w_sum[XLEN:1];
      w_lo_next = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign correction and result selection, consumed in FIX
  always_comb begin
    w_prod   = r_neg_res ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
    w_quo    = r_neg_res ? (~r_lo + 1'b1) : r_lo;
    w_rem    = r_neg_rem ? (~r_hi + 1'b1) : r_hi;
    w_result = '0;
    case (r_op)
      OP_MUL:                       w_result = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (r_b_zero)   w_result = '1;
        else if (r_ovf) w_result = MIN_NEG;
        else            w_result = w_quo;
      end
      OP_REM, OP_REMU: begin
        if (r_b_zero)   w_result = r_a_orig;
        else if (r_ovf) w_result = '0;
        else            w_result = w_rem;
      end
      default: w_result = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_CALC;
      S_CALC: if (r_cnt == LAST_ITER) w_state_next = S_FIX;
      S_FIX:  w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= '0;
      r_rd      <= '0;
      r_a_orig  <= '0;
      r_bmag    <= '0;
      r_b_zero  <= 1'b0;
      r_ovf     <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_wr_rd   <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op      <= funct3;
            r_rd      <= rd_in;
            r_a_orig  <= rs1_val;
            r_bmag    <= w_bmag;
            r_b_zero  <= (rs2_val == '0);
            r_ovf     <= w_signed_div && (rs1_val == MIN_NEG) && (rs2_val == '1);
            r_neg_res <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= w_amag;
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_wr_data <= w_result;
          r_wr_rd   <= r_rd;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Status outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (w_state_next == S_DONE);
      r_wr_en <= (w_state_next == S_DONE) && (r_rd != 5'd0);
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign wr_en   = r_wr_en;
  assign wr_rd   = r_wr_rd;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, timing, ignored
// starts, rd=0 suppression and mid-operation reset.
`timescale 1ns/1ps
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        en;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected write-back
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_data", wr_data, e.data);
        chk("wr_rd", {27'd0, wr_rd}, {27'd0, e.rd});
        chk("wr_en", {31'd0, wr_en}, {31'd0, e.en});
        $display("writeback rd=%0d data=0x%08h wr_en=%0b (expect 0x%08h)", wr_rd, wr_data, wr_en, e.data);
      end
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit disturb);
    int cyc;
    @(negedge clk);
    chk("idle_before_start", {31'd0, busy}, 32'd0);
    chk("no_done_before_start", {31'd0, done}, 32'd0);
    funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    exp_q.push_back('{rd: rd, data: exp, en: (rd != 5'd0)});
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_n1", {31'd0, busy}, 32'd1);
    if (disturb) begin
      funct3 = ~f; rs1_val = 32'h1234_5678; rs2_val = 32'h0000_0003; rd_in = ~rd;
    end
    while (!done && cyc < 45) begin
      start = (disturb && (cyc == 5 || cyc == 20 || cyc == 33)) ? 1'b1 : 1'b0;
      if (disturb) rs1_val = rs1_val + 32'd17;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, 34);
    chk("busy_n34", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int cyc;
    int bad_done;
    reset = 1'b1; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_wr_rd", {27'd0, wr_rd}, 32'd0);
    reset = 1'b0;

    run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b1);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0);
    run_op(3'b000, 32'h1234_5678, 32'h0000_0010, 5'd9,  32'h2345_6780, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 1'b1);
    run_op(3'b100, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 1'b0);
    run_op(3'b110, 32'd7,         32'hFFFF_FFFE, 5'd13, 32'h0000_0001, 1'b0);
    run_op(3'b101, 32'd20,        32'd0,         5'd14, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b111, 32'd20,        32'd0,         5'd15, 32'h0000_0014, 1'b0);
    run_op(3'b110, 32'hFFFF_FFFB, 32'd0,         5'd16, 32'hFFFF_FFFB, 1'b0);
    run_op(3'b100, 32'hFFFF_FFFB, 32'd0,         5'd17, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, 1'b0);
    run_op(3'b111, 32'd100,       32'd7,         5'd20, 32'h0000_0002, 1'b0);
    run_op(3'b101, 32'd100,       32'd7,         5'd0,  32'd14,        1'b0);

    // Mid-operation reset: aborted op must never write back
    @(negedge clk);
    funct3 = 3'b101; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd21; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_wr_data", wr_data, 32'd0);
    chk("abort_wr_rd", {27'd0, wr_rd}, 32'd0);
    chk("abort_wr_en", {31'd0, wr_en}, 32'd0);
    bad_done = 0;
    while (cyc < 40) begin
      if (done || wr_en || busy) bad_done++;
      @(negedge clk);
      cyc++;
    end
    chk("abort_quiet", bad_done, 0);

    run_op(3'b101, 32'd1000, 32'd3, 5'd22, 32'd333, 1'b0);
    repeat (40) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
